// File: rtl/rv32m_pkg.sv
// rv32m_pkg: shared RV32M op encodings, FSM states and sign helpers
`ifndef XLEN
`define XLEN 32
`endif
package rv32m_pkg;
  localparam int M_XLEN = `XLEN;
  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } m_f3_e;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } m_state_e;
  function automatic logic [M_XLEN-1:0] neg_xlen(input logic [M_XLEN-1:0] x);
    return ~x + 1'b1;
  endfunction
  function automatic logic [M_XLEN-1:0] abs_xlen(input logic [M_XLEN-1:0] x);
    return x[M_XLEN-1] ? neg_xlen(x) : x;
  endfunction
endpackage

// File: rtl/rv32m_divcore.sv
// rv32m_divcore: restoring divider, one shift/subtract step per cycle
// Ports: i_clk, i_rst (sync, active-low), start loads dividend/divisor,
// step advances one bit. quotient/remainder show the values the current
// step produces, so the caller can capture the final step's result on the
// same edge that performs it.
module rv32m_divcore #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            start,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  logic [XLEN-1:0] q, r, d;
  logic [XLEN:0] rs;
  logic ge;
  assign rs = {r, q[XLEN-1]};
  assign ge = rs >= {1'b0, d};
  assign remainder = ge ? rs[XLEN-1:0] - d : rs[XLEN-1:0];
  assign quotient = {q[XLEN-2:0], ge};
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      q <= '0;
      r <= '0;
      d <= '0;
    end else if (start) begin
      q <= dividend;
      r <= '0;
      d <= divisor;
    end else if (step) begin
      q <= quotient;
      r <= remainder;
    end
  end
endmodule

// File: rtl/rv32m_ext_unit.sv
// rv32m_ext_unit: external RV32M multiply/divide responder for the EX stage
// Ports: i_clk, i_rst (sync, active-low), i_en request pulse with i_rs1,
// i_rs2, i_f3; o_res result held after o_ack, o_ack one-cycle completion.
// RV32M_FAST_MUL_EN: multiplies finish combinationally at accept.
module rv32m_ext_unit
  import rv32m_pkg::*;
#(
  parameter int XLEN = M_XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [2:0]      i_f3,
  output logic [XLEN-1:0] o_res,
  output logic            o_ack
);
  localparam int CW = $clog2(XLEN);
  m_state_e state;
  m_f3_e f3_q;
  logic [CW-1:0] cnt;
  logic neg_q, neg_r, sa, sb, s1, s2, dbz, accept, fast;
  logic [2*XLEN-1:0] p, p_n, pf;
  logic [XLEN:0] sum;
  logic [XLEN-1:0] mcand, a_mag, b_mag, quo, rem, res_mul, res_div, res_fin, res_fast;
  assign accept = state == IDLE && i_en;
  // Which operands are treated as signed: DIV/REM both, MUL/MULH both,
  // MULHSU only rs1, unsigned variants neither.
  assign sa = i_f3[2] ? ~i_f3[0] : i_f3[1:0] != 2'b11;
  assign sb = i_f3[2] ? ~i_f3[0] : ~i_f3[1];
  assign s1 = sa & i_rs1[XLEN-1];
  assign s2 = sb & i_rs2[XLEN-1];
  assign a_mag = sa ? abs_xlen(i_rs1) : i_rs1;
  assign b_mag = sb ? abs_xlen(i_rs2) : i_rs2;
  assign dbz = i_f3[2] && i_rs2 == '0;
  // Shift-add: multiplier sits in the low half of p and drains out the
  // bottom while partial sums enter the top.
  assign sum = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, mcand} : '0);
  assign p_n = {sum, p[XLEN-1:1]};
  assign pf = neg_q ? -p_n : p_n;
  assign res_mul = f3_q == F3_MUL ? pf[XLEN-1:0] : pf[2*XLEN-1:XLEN];
  assign res_div = f3_q[1] ? (neg_r ? neg_xlen(rem) : rem) : (neg_q ? neg_xlen(quo) : quo);
  assign res_fin = f3_q[2] ? res_div : res_mul;
  assign o_ack = state == DONE;
`ifdef RV32M_FAST_MUL_EN
  logic [2*XLEN-1:0] fp;
  assign fp = {{XLEN{s1}}, i_rs1} * {{XLEN{s2}}, i_rs2};
  assign fast = ~i_f3[2];
  assign res_fast = i_f3 == F3_MUL ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
`else
  assign fast = 1'b0;
  assign res_fast = '0;
`endif
  rv32m_divcore #(.XLEN(XLEN)) u_div (
    .i_clk,
    .i_rst,
    .start(accept),
    .step(state == CALC),
    .dividend(a_mag),
    .divisor(b_mag),
    .quotient(quo),
    .remainder(rem)
  );
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= IDLE;
      cnt <= '0;
      o_res <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        f3_q <= m_f3_e'(i_f3);
        neg_q <= s1 ^ s2;
        neg_r <= s1;
        p <= {{XLEN{1'b0}}, b_mag};
        mcand <= a_mag;
        cnt <= '0;
        if (dbz) o_res <= i_f3[1] ? i_rs1 : '1;
        else if (fast) o_res <= res_fast;
        state <= dbz || fast ? DONE : CALC;
      end
    end else if (state == CALC) begin
      p <= p_n;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(XLEN - 1)) begin
        o_res <= res_fin;
        state <= DONE;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_rv32m_ext_unit.sv
// tb_rv32m_ext_unit: directed self-checking bench for rv32m_ext_unit
module tb_rv32m_ext_unit;
  logic i_clk = 0, i_rst = 0, i_en = 0;
  logic [31:0] i_rs1 = 0, i_rs2 = 0, o_res;
  logic [2:0] i_f3 = 0;
  logic o_ack;
  int n_chk = 0, n_err = 0;
`ifdef RV32M_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  rv32m_ext_unit dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_en(i_en),
    .i_rs1(i_rs1),
    .i_rs2(i_rs2),
    .i_f3(i_f3),
    .o_res(o_res),
    .o_ack(o_ack)
  );
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_res, input int exp_lat);
    int lat = 0;
    bit got = 0;
    i_en = 1; i_f3 = f3; i_rs1 = a; i_rs2 = b;
    while (!got && lat < 100) begin
      @(negedge i_clk);
      lat++;
      i_en = 0; i_rs1 = ~a; i_rs2 = ~b; i_f3 = ~f3;
      if (o_ack) got = 1;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, o_res, exp_res);
    @(negedge i_clk);
    check({tag, "_ack1"}, {31'd0, o_ack}, 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int acks;
    logic [31:0] res;
    repeat (3) @(negedge i_clk);
    check("rst_ack", {31'd0, o_ack}, 32'd0);
    check("rst_res", o_res, 32'd0);
    i_rst = 1;
    @(negedge i_clk);
    run("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
    run("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
    run("mulh", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT);
    run("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT);
    run("mul67", 3'b000, 32'd6, 32'd7, 32'd42, MUL_LAT);
    run("div", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    run("divu0", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    run("rem0", 3'b110, 32'd5, 32'd0, 32'd5, 1);
    run("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
    run("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33);
    run("remu", 3'b111, 32'd100, 32'd7, 32'd2, 33);
    i_en = 1; i_f3 = 3'b101; i_rs1 = 32'd100; i_rs2 = 32'd7;
    repeat (10) begin
      @(negedge i_clk);
      i_en = 0;
    end
    i_rst = 0;
    @(negedge i_clk);
    i_rst = 1;
    acks = 0;
    repeat (60) begin
      @(negedge i_clk);
      if (o_ack) acks++;
    end
    check("abort_acks", 32'(acks), 32'd0);
    check("abort_res", o_res, 32'd0);
    run("post_rst", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    i_en = 1; i_f3 = 3'b101; i_rs1 = 32'd100; i_rs2 = 32'd7;
    acks = 0;
    res = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge i_clk);
      i_en = k == 5;
      if (k == 5) begin
        i_f3 = 3'b101; i_rs1 = 32'd5; i_rs2 = 32'd0;
      end
      if (o_ack) begin
        acks++;
        res = o_res;
      end
    end
    check("dbl_acks", 32'(acks), 32'd1);
    check("dbl_res", res, 32'd14);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
